// File: rtl/deepfifo_pkg.sv
// Shared types and constants for the deep FIFO frame packer.
package deepfifo_pkg;

  localparam int WORD_W   = 32;
  localparam int SAMPLE_W = 16;

  localparam logic [7:0] HEADER_MAGIC  = 8'hA5;
  localparam logic [7:0] TRAILER_MAGIC = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2,
    ST_TRAILER = 2'd3
  } state_e;

endpackage

// File: rtl/deepfifo_packer.sv
// Packs 16-bit samples two per 32-bit word into framed writes with per-frame admission.
// Optional trailer word enabled by defining DEEPFIFO_PACKER_TRAILER_EN.
module deepfifo_packer
  import deepfifo_pkg::*;
#(
  parameter int log2_fifo_words    = 9,
  parameter int log2_frame_samples = 7,
  parameter int space_margin       = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       frame_start,
  input  logic                       sample_valid,
  input  logic [SAMPLE_W-1:0]        sample_data,
  output logic                       fifo_pre_wr_en,
  output logic [WORD_W-1:0]          fifo_pre_din,
  input  logic                       fifo_pre_full,
  input  logic [log2_fifo_words:0]   fifo_pre_wr_count,
  output logic [15:0]                frame_count,
  output logic [15:0]                drop_count,
  output logic                       overflow,
  output logic                       busy
);

`ifdef DEEPFIFO_PACKER_TRAILER_EN
  localparam int TRAILER_WORDS = 1;
`else
  localparam int TRAILER_WORDS = 0;
`endif
  localparam int FRAME_WORDS = (1 << (log2_frame_samples - 1)) + 1 + TRAILER_WORDS;
  localparam int FREE_W      = log2_fifo_words + 2;
  localparam int DEPTH_I     = 1 << log2_fifo_words;
  localparam logic [FREE_W-1:0] DEPTH      = FREE_W'(DEPTH_I);
  localparam logic [FREE_W-1:0] NEED_WORDS = FREE_W'(FRAME_WORDS + space_margin);
  localparam logic [log2_frame_samples-1:0] CNT_ONE  = log2_frame_samples'(1);
  localparam logic [log2_frame_samples-1:0] CNT_LAST = {log2_frame_samples{1'b1}};

  state_e                          state_q, state_d;
  logic [log2_frame_samples-1:0]   cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]             low_q, low_d;
  logic [15:0]                     frame_count_q, frame_count_d;
  logic [15:0]                     drop_count_q, drop_count_d;
  logic                            overflow_q, overflow_d;
  logic                            wr_en_q, wr_en_d;
  logic [WORD_W-1:0]               din_q, din_d;
  logic                            busy_q, busy_d;

  logic [FREE_W-1:0]               free_s;
  logic                            space_ok_s;

  assign free_s     = DEPTH - {1'b0, fifo_pre_wr_count};
  assign space_ok_s = (free_s >= NEED_WORDS) && !fifo_pre_full;

  // Next-state, packing and counter logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    low_d         = low_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    wr_en_d       = 1'b0;
    din_d         = din_q;
    // The FIFO sees the registered strobe, so full is judged against it.
    overflow_d    = overflow_q | (wr_en_q & fifo_pre_full);

    case (state_q)
      ST_IDLE: begin
        if (frame_start && sample_valid) begin
          frame_count_d = frame_count_q + 16'd1;
          cnt_d         = CNT_ONE;
          low_d         = sample_data;
          if (space_ok_s) begin
            state_d = ST_PAYLOAD;
            wr_en_d = 1'b1;
            din_d   = {HEADER_MAGIC, 8'(log2_frame_samples), frame_count_q};
          end else begin
            state_d = ST_DROP;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
            else                          drop_count_d = drop_count_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD, ST_DROP: begin
        if (sample_valid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q[0]) begin
            wr_en_d = (state_q == ST_PAYLOAD);
            din_d   = (state_q == ST_PAYLOAD) ? {sample_data, low_q} : din_q;
          end else begin
            low_d = sample_data;
          end
          if (cnt_q == CNT_LAST) begin
`ifdef DEEPFIFO_PACKER_TRAILER_EN
            state_d = (state_q == ST_PAYLOAD) ? ST_TRAILER : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_TRAILER: begin
`ifdef DEEPFIFO_PACKER_TRAILER_EN
        wr_en_d = 1'b1;
        din_d   = {TRAILER_MAGIC, 8'h00, drop_count_q};
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      low_q         <= 16'h0000;
      frame_count_q <= 16'h0000;
      drop_count_q  <= 16'h0000;
      overflow_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      din_q         <= 32'h0000_0000;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      low_q         <= low_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
      wr_en_q       <= wr_en_d;
      din_q         <= din_d;
      busy_q        <= busy_d;
    end
  end

  assign fifo_pre_wr_en = wr_en_q;
  assign fifo_pre_din   = din_q;
  assign frame_count    = frame_count_q;
  assign drop_count     = drop_count_q;
  assign overflow       = overflow_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_deepfifo_packer.sv
// Scoreboard bench for deepfifo_packer: a frame-level model queues expected writes, a monitor checks them.
module tb_deepfifo_packer;

  localparam int L2FW = 9;
  localparam int L2FS = 2;
  localparam int NS   = 1 << L2FS;
`ifdef DEEPFIFO_PACKER_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif
  localparam int NEED = NS / 2 + 1 + TRL + 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_start = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = 16'h0000;
  logic        fifo_pre_wr_en;
  logic [31:0] fifo_pre_din;
  logic        fifo_pre_full = 1'b0;
  logic [L2FW:0] fifo_pre_wr_count = '0;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        busy;

  deepfifo_packer #(.log2_fifo_words(L2FW), .log2_frame_samples(L2FS), .space_margin(8)) dut (
    .clk(clk), .resetn(resetn), .frame_start(frame_start), .sample_valid(sample_valid),
    .sample_data(sample_data), .fifo_pre_wr_en(fifo_pre_wr_en), .fifo_pre_din(fifo_pre_din),
    .fifo_pre_full(fifo_pre_full), .fifo_pre_wr_count(fifo_pre_wr_count),
    .frame_count(frame_count), .drop_count(drop_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Frame-level reference model state.
  int          m_left = 0;
  int          m_idx = 0;
  bit          m_admit = 1'b0;
  bit          m_trl = 1'b0;
  logic [15:0] m_low = 16'h0000;
  logic [15:0] m_frames = 16'h0000;
  logic [15:0] m_drops = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic model_step(input bit fs, input bit sv, input logic [15:0] d,
                            input int wc, input bit full);
    if (m_trl) begin
      push({8'h5A, 8'h00, m_drops});
      m_trl = 1'b0;
    end else if (m_left == 0) begin
      if (fs && sv) begin
        m_admit = ((512 - wc) >= NEED) && !full;
        if (m_admit) push({8'hA5, 8'(L2FS), m_frames});
        else if (m_drops != 16'hFFFF) m_drops++;
        m_frames++;
        m_idx  = 1;
        m_left = NS - 1;
        m_low  = d;
      end
    end else if (sv) begin
      if (m_admit) begin
        if (m_idx % 2 == 1) push({d, m_low});
        else m_low = d;
      end
      m_idx++;
      m_left--;
      if (m_left == 0 && m_admit && TRL == 1) m_trl = 1'b1;
    end
  endtask

  task automatic step(input bit fs, input bit sv, input logic [15:0] d,
                      input int wc = 0, input bit full = 1'b0);
    @(negedge clk);
    frame_start       = fs;
    sample_valid      = sv;
    sample_data       = d;
    fifo_pre_wr_count = (L2FW + 1)'(wc);
    fifo_pre_full     = full;
    model_step(fs, sv, d, wc, full);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic frame(input logic [15:0] base, input int wc = 0);
    step(1'b1, 1'b1, base, wc);
    for (int i = 1; i < NS; i++) step(1'b0, 1'b1, base + 16'(i));
  endtask

  // Monitor: every write strobe must match the next expected word at the expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (resetn === 1'b1 && fifo_pre_wr_en === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_write", fifo_pre_din, 32'h0000_0000 ^ ~fifo_pre_din);
        end else begin
          e = q.pop_front();
          chk("write_data", fifo_pre_din, e.data);
          chk("write_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #3;
    chk("rst_wr_en", {31'd0, fifo_pre_wr_en}, 32'd0);
    chk("rst_din", fifo_pre_din, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    idle(2);

    // Basic frame 1,2,3,4.
    step(1'b1, 1'b1, 16'd1);
    step(1'b0, 1'b1, 16'd2);
    idle(1);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    step(1'b0, 1'b1, 16'd3);
    step(1'b0, 1'b1, 16'd4);
    idle(3);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("frame_count_1", {16'd0, frame_count}, {16'd0, m_frames});

    // Nearly full FIFO: frame dropped, next header carries the updated count.
    frame(16'h0100, 508);
    idle(2);
    chk("drop_count", {16'd0, drop_count}, {16'd0, m_drops});
    chk("drop_frame_count", {16'd0, frame_count}, {16'd0, m_frames});
    frame(16'h0200);
    idle(3);

    // Gapped samples.
    step(1'b1, 1'b1, 16'h0A00);
    idle(1);
    step(1'b0, 1'b1, 16'h0A01);
    idle(2);
    step(1'b1, 1'b1, 16'h0A02);
    idle(1);
    step(1'b0, 1'b1, 16'h0A03);
    idle(3);

    // Back-to-back frames.
    frame(16'h1000);
    frame(16'h2000);
    frame(16'h3000);
    idle(3);

    // Full during payload.
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    step(1'b1, 1'b1, 16'h4000);
    for (int i = 1; i < NS; i++) step(1'b0, 1'b1, 16'h4000 + 16'(i), 0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 0, 1'b1);
    idle(3);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    frame(16'h5000);
    idle(3);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit fs, sv, full;
      int wc;
      fs   = ($urandom % 6) == 0;
      sv   = ($urandom % 4) != 0;
      wc   = (($urandom % 5) == 0) ? 495 + int'($urandom % 18) : int'($urandom % 100);
      full = ($urandom % 60) == 0;
      step(fs, sv, 16'($urandom), wc, full);
    end
    idle(4);
    chk("rand_frame_count", {16'd0, frame_count}, {16'd0, m_frames});
    chk("rand_drop_count", {16'd0, drop_count}, {16'd0, m_drops});
    chk("rand_queue_empty", q.size(), 32'd0);

    // Reset in the middle of a payload.
    step(1'b1, 1'b1, 16'h6000);
    step(1'b0, 1'b1, 16'h6001);
    step(1'b0, 1'b1, 16'h6002);
    #2;
    frame_start = 1'b0;
    sample_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, fifo_pre_wr_en}, 32'd0);
    chk("mid_rst_din", fifo_pre_din, 32'd0);
    chk("mid_rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    q.delete();
    m_left = 0; m_idx = 0; m_admit = 1'b0; m_trl = 1'b0;
    m_frames = 16'h0000; m_drops = 16'h0000;
    @(negedge clk);
    resetn = 1'b1;
    frame(16'h7000);
    idle(4);
    chk("post_rst_frame_count", {16'd0, frame_count}, {16'd0, m_frames});
    chk("final_queue_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
